// File: rtl/vadd_launch_ctrl.sv
// AXI4-Lite master that programs krnl_vadd (a, b, c, length_r), sets ap_start, polls ap_done
// and reports a completion record. Optional poll timeout: define VADD_LAUNCH_TIMEOUT_EN.
module vadd_launch_ctrl #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] CTRL_OFF = 'h00,
    parameter logic [ADDR_W-1:0] A_OFF    = 'h10,
    parameter logic [ADDR_W-1:0] B_OFF    = 'h1C,
    parameter logic [ADDR_W-1:0] C_OFF    = 'h28,
    parameter logic [ADDR_W-1:0] LEN_OFF  = 'h34,
    parameter int                POLL_GAP = 16,
    parameter int unsigned       TIMEOUT  = 2**20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [63:0]       cmd_a,
    input  logic [63:0]       cmd_b,
    input  logic [63:0]       cmd_c,
    input  logic [31:0]       cmd_len,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [1:0]        done_status,
    output logic [31:0]       done_cycles,
    output logic              busy,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [1:0]        m_bresp,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_POLL_AR, S_POLL_R, S_GAP, S_RESP} state_t;

    state_t      state;
    logic [63:0] a_q, b_q, c_q;
    logic [31:0] len_q;
    logic [2:0]  idx;
    logic [31:0] gap_cnt;
    logic        tmo;

    // Only ap_done is looked at in the poll response.
    logic unused_rdata;
    assign unused_rdata = ^{m_rdata[31:2], m_rdata[0]};

`ifdef VADD_LAUNCH_TIMEOUT_EN
    assign tmo = (done_cycles >= TIMEOUT);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign tmo = 1'b0;
`endif

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign m_wstrb   = 4'hF;

    function automatic logic [ADDR_W-1:0] reg_addr(input logic [2:0] i);
        case (i)
            3'd0:    reg_addr = A_OFF;
            3'd1:    reg_addr = A_OFF + ADDR_W'(4);
            3'd2:    reg_addr = B_OFF;
            3'd3:    reg_addr = B_OFF + ADDR_W'(4);
            3'd4:    reg_addr = C_OFF;
            3'd5:    reg_addr = C_OFF + ADDR_W'(4);
            3'd6:    reg_addr = LEN_OFF;
            default: reg_addr = CTRL_OFF;
        endcase
    endfunction

    function automatic logic [31:0] reg_data(input logic [2:0] i, input logic [63:0] a,
                                             input logic [63:0] b, input logic [63:0] c,
                                             input logic [31:0] len);
        case (i)
            3'd0:    reg_data = a[31:0];
            3'd1:    reg_data = a[63:32];
            3'd2:    reg_data = b[31:0];
            3'd3:    reg_data = b[63:32];
            3'd4:    reg_data = c[31:0];
            3'd5:    reg_data = c[63:32];
            3'd6:    reg_data = len;
            default: reg_data = 32'h1;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            len_q       <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
            done_valid  <= 1'b0;
            done_status <= '0;
            done_cycles <= '0;
            m_awvalid   <= 1'b0;
            m_awaddr    <= '0;
            m_wvalid    <= 1'b0;
            m_wdata     <= '0;
            m_bready    <= 1'b0;
            m_arvalid   <= 1'b0;
            m_araddr    <= '0;
            m_rready    <= 1'b0;
        end else begin
            // Cycle count runs only while waiting on the kernel; it saturates rather than wraps.
            if ((state inside {S_POLL_AR, S_POLL_R, S_GAP}) && done_cycles != '1)
                done_cycles <= done_cycles + 32'd1;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    a_q         <= cmd_a;
                    b_q         <= cmd_b;
                    c_q         <= cmd_c;
                    len_q       <= cmd_len;
                    idx         <= '0;
                    m_awaddr    <= reg_addr(3'd0);
                    m_wdata     <= reg_data(3'd0, cmd_a, cmd_b, cmd_c, cmd_len);
                    m_awvalid   <= 1'b1;
                    m_wvalid    <= 1'b1;
                    done_status <= '0;
                    done_cycles <= '0;
                    state       <= S_WR;
                end
                S_WR: begin
                    if (m_awready) m_awvalid <= 1'b0;
                    if (m_wready)  m_wvalid  <= 1'b0;
                    if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                        m_bready <= 1'b1;
                        state    <= S_WB;
                    end
                end
                S_WB: if (m_bvalid) begin
                    m_bready <= 1'b0;
                    if (m_bresp != 2'b00) begin
                        done_status <= 2'd1;
                        done_valid  <= 1'b1;
                        state       <= S_RESP;
                    end else if (idx == 3'd7) begin
                        done_cycles <= '0;
                        m_arvalid   <= 1'b1;
                        m_araddr    <= CTRL_OFF;
                        state       <= S_POLL_AR;
                    end else begin
                        idx       <= idx + 3'd1;
                        m_awaddr  <= reg_addr(idx + 3'd1);
                        m_wdata   <= reg_data(idx + 3'd1, a_q, b_q, c_q, len_q);
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        state     <= S_WR;
                    end
                end
                S_POLL_AR: if (m_arready) begin
                    m_arvalid <= 1'b0;
                    m_rready  <= 1'b1;
                    state     <= S_POLL_R;
                end
                S_POLL_R: if (m_rvalid) begin
                    m_rready <= 1'b0;
                    if (m_rresp != 2'b00) begin
                        done_status <= 2'd2;
                        done_valid  <= 1'b1;
                        state       <= S_RESP;
                    end else if (m_rdata[1]) begin
                        done_status <= 2'd0;
                        done_valid  <= 1'b1;
                        state       <= S_RESP;
                    end else if (tmo) begin
                        done_status <= 2'd3;
                        done_valid  <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tmo) begin
                        done_status <= 2'd3;
                        done_valid  <= 1'b1;
                        state       <= S_RESP;
                    end else if (gap_cnt == 32'(POLL_GAP - 1)) begin
                        m_arvalid <= 1'b1;
                        state     <= S_POLL_AR;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                S_RESP: if (done_ready) begin
                    done_valid <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vadd_launch_ctrl.sv
// Bench for vadd_launch_ctrl: behavioural AXI-Lite kernel slave plus write/completion scoreboard.
module tb_vadd_launch_ctrl;
    localparam int POLL_GAP = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        cmd_valid = 1'b0, cmd_ready, done_valid, done_ready = 1'b0, busy;
    logic [63:0] cmd_a = '0, cmd_b = '0, cmd_c = '0;
    logic [31:0] cmd_len = '0, done_cycles;
    logic [1:0]  done_status;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [11:0] m_awaddr, m_araddr;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    vadd_launch_ctrl #(.POLL_GAP(POLL_GAP), .TIMEOUT(200)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_c(cmd_c), .cmd_len(cmd_len), .done_valid(done_valid), .done_ready(done_ready),
        .done_status(done_status), .done_cycles(done_cycles), .busy(busy),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    int tests_run = 0, tests_failed = 0;

    // Slave behaviour knobs: aw_mode 0 zero-wait, 1 AW late after W, 2 W late after AW.
    int aw_mode = 0, berr_idx = -1, rerr_poll = -1, done_poll = 1;

    logic        aw_got, w_got, wr_evt, dup_err, ar_bad;
    logic [11:0] aw_q, ev_addr;
    logic [31:0] w_q, ev_data;
    logic [3:0]  s_q, ev_strb;
    int          dcnt, wr_cnt, ar_cnt;

    assign m_awready = (aw_mode == 1) ? (w_got && !aw_got && dcnt >= 3) : 1'b1;
    assign m_wready  = (aw_mode == 2) ? (aw_got && !w_got && dcnt >= 3) : 1'b1;
    assign m_arready = 1'b1;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            aw_got <= 0; w_got <= 0; wr_evt <= 0; dup_err <= 0; ar_bad <= 0;
            aw_q <= 0; w_q <= 0; s_q <= 0; ev_addr <= 0; ev_data <= 0; ev_strb <= 0;
            dcnt <= 0; wr_cnt <= 0; ar_cnt <= 0;
            m_bvalid <= 0; m_bresp <= 0; m_rvalid <= 0; m_rdata <= 0; m_rresp <= 0;
        end else begin
            wr_evt <= 1'b0;
            dcnt   <= (aw_got ^ w_got) ? dcnt + 1 : 0;
            if (m_awvalid && m_awready) begin
                if (aw_got) dup_err <= 1'b1;
                aw_got <= 1'b1; aw_q <= m_awaddr;
            end
            if (m_wvalid && m_wready) begin
                if (w_got) dup_err <= 1'b1;
                w_got <= 1'b1; w_q <= m_wdata; s_q <= m_wstrb;
            end
            if (aw_got && w_got && !m_bvalid) begin
                m_bvalid <= 1'b1;
                m_bresp  <= (wr_cnt == berr_idx) ? 2'b10 : 2'b00;
                aw_got <= 1'b0; w_got <= 1'b0;
                wr_evt <= 1'b1; ev_addr <= aw_q; ev_data <= w_q; ev_strb <= s_q;
                wr_cnt <= wr_cnt + 1;
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                if (m_araddr != 12'h000) ar_bad <= 1'b1;
                ar_cnt   <= ar_cnt + 1;
                m_rvalid <= 1'b1;
                m_rresp  <= (ar_cnt + 1 == rerr_poll) ? 2'b10 : 2'b00;
                m_rdata  <= (ar_cnt + 1 >= done_poll) ? 32'h2 : 32'h0;
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
        end
    end

    typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
    wr_t        exp_wr[$];
    logic [1:0] exp_st[$];

    task automatic do_reset();
        reset = 1'b0; cmd_valid = 1'b0; done_ready = 1'b0;
        aw_mode = 0; berr_idx = -1; rerr_poll = -1; done_poll = 1;
        exp_wr.delete(); exp_st.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic send_cmd(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                            input logic [31:0] len);
        @(negedge clock);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_c = c; cmd_len = len;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clock);
        @(negedge clock);
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_len = '0;
    endtask

    task automatic drive_cmd(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                             input logic [31:0] len, input int nwr, input logic [1:0] st);
        logic [31:0] d[8];
        logic [11:0] ad[8];
        wr_t e;
        d  = '{a[31:0], a[63:32], b[31:0], b[63:32], c[31:0], c[63:32], len, 32'h1};
        ad = '{12'h10, 12'h14, 12'h1C, 12'h20, 12'h28, 12'h2C, 12'h34, 12'h00};
        for (int i = 0; i < nwr; i++) begin e.addr = ad[i]; e.data = d[i]; exp_wr.push_back(e); end
        exp_st.push_back(st);
        send_cmd(a, b, c, len);
    endtask

    task automatic wait_done(input int budget, output logic [1:0] st, output logic [31:0] cy);
        bit seen = 0;
        wr_t e;
        logic [1:0] est;
        st = 2'b00; cy = '0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (wr_evt) begin
                tests_run++;
                if (exp_wr.size() == 0) begin
                    tests_failed++;
                    $display("FAIL write_extra addr=%h data=%h", ev_addr, ev_data);
                end else begin
                    e = exp_wr.pop_front();
                    if ({ev_addr, ev_data, ev_strb} !== {e.addr, e.data, 4'hF}) begin
                        tests_failed++;
                        $display("FAIL write got addr=%h data=%h strb=%h exp addr=%h data=%h strb=f",
                                 ev_addr, ev_data, ev_strb, e.addr, e.data);
                    end
                end
            end
            if (done_valid) begin seen = 1; st = done_status; cy = done_cycles; end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL done_wait got=no_done exp=done within %0d cycles", budget);
        end else begin
            est = (exp_st.size() != 0) ? exp_st.pop_front() : 2'bxx;
            if (st !== est) begin
                tests_failed++;
                $display("FAIL done_status got=%0d exp=%0d", st, est);
            end
        end
        tests_run++;
        if (exp_wr.size() != 0) begin
            tests_failed++;
            $display("FAIL writes_missing got=%0d left exp=0", exp_wr.size());
        end
    endtask

    task automatic ack_done();
        @(negedge clock); done_ready = 1'b1;
        @(negedge clock); done_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({cmd_ready, busy, done_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 8'b1000_0000) begin
            tests_failed++;
            $display("FAIL reset_ctl got=%b exp=10000000",
                     {cmd_ready, busy, done_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        end
        tests_run++;
        if ({m_awaddr, m_wdata, m_araddr, done_status, done_cycles} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data got awaddr=%h wdata=%h st=%0d cy=%0d exp=0",
                     m_awaddr, m_wdata, done_status, done_cycles);
        end
    endtask

    task automatic test_basic();
        logic [1:0] st; logic [31:0] cy;
        do_reset();
        drive_cmd(64'h1_0000_1000, 64'h2_0000_2000, 64'h3_0000_3000, 32'd256, 8, 2'd0);
        tests_run++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy got busy=%b cmd_ready=%b exp busy=1 cmd_ready=0", busy, cmd_ready);
        end
        wait_done(1000, st, cy);
        tests_run++;
        if (ar_cnt !== 1 || ar_bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_polls got ar=%0d bad=%b exp ar=1 bad=0", ar_cnt, ar_bad);
        end
        ack_done();
        tests_run++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_idle got cmd_ready=%b busy=%b exp 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_skew();
        logic [1:0] st; logic [31:0] cy;
        for (int m = 1; m <= 2; m++) begin
            do_reset();
            aw_mode = m;
            drive_cmd(64'hA5A5_0000_0040, 64'h5A5A_0000_0080, 64'h0F0F_0000_00C0, 32'd17, 8, 2'd0);
            wait_done(2000, st, cy);
            tests_run++;
            if (dup_err !== 1'b0 || wr_cnt !== 8) begin
                tests_failed++;
                $display("FAIL skew_mode%0d got dup=%b writes=%0d exp dup=0 writes=8", m, dup_err, wr_cnt);
            end
            ack_done();
        end
    endtask

    task automatic test_polls();
        logic [1:0] st; logic [31:0] cy;
        int model;
        do_reset();
        done_poll = 3;
        model = 2 * (POLL_GAP + 2) + 2;
        drive_cmd(64'h10, 64'h20, 64'h30, 32'd64, 8, 2'd0);
        wait_done(2000, st, cy);
        tests_run++;
        if (ar_cnt !== 3) begin
            tests_failed++;
            $display("FAIL polls_ar got=%0d exp=3", ar_cnt);
        end
        tests_run++;
        if (int'(cy) < model - 2 || int'(cy) > model + 2) begin
            tests_failed++;
            $display("FAIL polls_cycles got=%0d exp=%0d+-2", cy, model);
        end
        ack_done();
    endtask

    task automatic test_errors();
        logic [1:0] st; logic [31:0] cy;
        do_reset();
        berr_idx = 3;
        drive_cmd(64'h7_0000_0700, 64'h8_0000_0800, 64'h9_0000_0900, 32'd5, 4, 2'd1);
        wait_done(1000, st, cy);
        repeat (5) @(negedge clock);
        tests_run++;
        if (wr_cnt !== 4 || ar_cnt !== 0) begin
            tests_failed++;
            $display("FAIL berr_stop got writes=%0d ar=%0d exp writes=4 ar=0", wr_cnt, ar_cnt);
        end
        ack_done();
        do_reset();
        done_poll = 1000; rerr_poll = 2;
        drive_cmd(64'h1, 64'h2, 64'h3, 32'd4, 8, 2'd2);
        wait_done(2000, st, cy);
        tests_run++;
        if (ar_cnt !== 2) begin
            tests_failed++;
            $display("FAIL rerr_polls got=%0d exp=2", ar_cnt);
        end
        ack_done();
    endtask

    task automatic test_back_to_back();
        logic [1:0] st; logic [31:0] cy;
        do_reset();
        drive_cmd(64'hDEAD_BEEF_0000_1000, 64'hCAFE_0000_2000, 64'hF00D_0000_3000, 32'd9, 8, 2'd0);
        wait_done(1000, st, cy);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            tests_run++;
            if (done_valid !== 1'b1 || done_status !== st || done_cycles !== cy || cmd_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_stable got v=%b st=%0d cy=%0d rdy=%b exp v=1 st=%0d cy=%0d rdy=0",
                         done_valid, done_status, done_cycles, cmd_ready, st, cy);
            end
        end
        ack_done();
        tests_run++;
        if (cmd_ready !== 1'b1 || done_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_release got rdy=%b v=%b exp rdy=1 v=0", cmd_ready, done_valid);
        end
        drive_cmd(64'h4_0000_4000, 64'h5_0000_5000, 64'h6_0000_6000, 32'd0, 8, 2'd0);
        wait_done(1000, st, cy);
        ack_done();
    endtask

`ifdef VADD_LAUNCH_TIMEOUT_EN
    task automatic test_timeout();
        logic [1:0] st; logic [31:0] cy;
        do_reset();
        done_poll = 1000;
        drive_cmd(64'h1, 64'h2, 64'h3, 32'd8, 8, 2'd3);
        wait_done(3000, st, cy);
        tests_run++;
        if (cy < 32'd200 || cy > 32'd240) begin
            tests_failed++;
            $display("FAIL timeout_cycles got=%0d exp=200..240", cy);
        end
        ack_done();
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        send_cmd(64'h1_0000_1000, 64'h2_0000_2000, 64'h3_0000_3000, 32'd256);
        for (int i = 0; i < 50 && !(m_awvalid && m_wvalid); i++) @(negedge clock);
        tests_run++;
        if (m_awvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_wr got awvalid=%b exp=1", m_awvalid);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({cmd_ready, busy, done_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 8'b1000_0000 ||
            {m_awaddr, m_wdata, done_status, done_cycles} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset got ctl=%b awaddr=%h wdata=%h exp ctl=10000000 awaddr=0 wdata=0",
                     {cmd_ready, busy, done_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready},
                     m_awaddr, m_wdata);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_polls();
        test_errors();
        test_back_to_back();
`ifdef VADD_LAUNCH_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
